// File: rtl/fft256_pkg.sv
// Shared constants for the 256-point FFT datapath: frame geometry and the
// reorder controller's state encodings.
package fft256_pkg;

  localparam int FRAME_LEN = 256;
  localparam int AW        = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } fft_state_e;

endpackage

// File: rtl/RAM256.sv
// 256-word single-port RAM with a two-stage read (address register, then data
// register). Everything, including writes, is frozen while ED is low.
module RAM256
  import fft256_pkg::*;
#(
  parameter int nb = 24
) (
  input  logic          CLK,
  input  logic          ED,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [nb-1:0] DI,
  output logic [nb-1:0] DO
);

  logic [nb-1:0] mem [FRAME_LEN];
  logic [AW-1:0] addr_q;
  logic [nb-1:0] do_q;

  always_ff @(posedge CLK) begin
    if (ED) begin
      if (WE) begin
        mem[ADDR] <= DI;
      end
      addr_q <= ADDR;
      do_q   <= mem[addr_q];
    end
  end

  assign DO = do_q;

endmodule

// File: rtl/bitrev_reorder256.sv
// Reorders 256-sample complex frames from natural to bit-reversed order using
// two ping-pong RAM banks: one bank fills while the other is read out.
module bitrev_reorder256
  import fft256_pkg::*;
#(
  parameter int nb = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          START,
  input  logic [nb-1:0] DR,
  input  logic [nb-1:0] DI,
  output logic [nb-1:0] DOR,
  output logic [nb-1:0] DOI,
  output logic          RDY
);

  localparam int DW = 2 * nb;

  function automatic logic [AW-1:0] bitrev8(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  fft_state_e    state_q;
  logic [AW-1:0] wa_q;
  logic [AW-1:0] ra_q;
  logic [AW-1:0] ra_d;
  logic          ws_q;
  logic          rd_act_q;
  logic          rd_act_d;
  logic          v1_q, v2_q;
  logic          f1_q, f2_q;
  logic          b1_q, b2_q;
  logic [nb-1:0] dor_q;
  logic [nb-1:0] doi_q;
  logic          rdy_q;
  logic          wr_en;
  logic          wrap;
  logic [DW-1:0] bank_do [2];
  logic [DW-1:0] rd_word;

  // START wins over the write, so a START on the last sample suppresses the wrap.
  assign wr_en   = ~RST & ~START & (state_q != ST_IDLE);
  assign wrap    = wr_en & (wa_q == AW'(FRAME_LEN - 1));
  assign rd_word = bank_do[b2_q];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK = 1'(gi);
    logic [AW-1:0] addr;
    logic          we;

    assign we   = wr_en & (ws_q == BANK);
    assign addr = (ws_q == BANK) ? wa_q : bitrev8(ra_q);

    RAM256 #(.nb(DW)) u_ram (
      .CLK  (CLK),
      .ED   (ED),
      .WE   (we),
      .ADDR (addr),
      .DI   ({DR, DI}),
      .DO   (bank_do[gi])
    );
  end

  always_comb begin
    ra_d     = ra_q;
    rd_act_d = rd_act_q;
    if (rd_act_q) begin
      ra_d = ra_q + 1'b1;
      if (ra_q == AW'(FRAME_LEN - 1)) begin
        rd_act_d = 1'b0;
      end
    end
    // A freshly completed frame restarts the read counter even mid-readout.
    if (wrap) begin
      ra_d     = '0;
      rd_act_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      wa_q     <= '0;
      ra_q     <= '0;
      ws_q     <= 1'b0;
      rd_act_q <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      b1_q     <= 1'b0;
      b2_q     <= 1'b0;
      dor_q    <= '0;
      doi_q    <= '0;
      rdy_q    <= 1'b0;
    end else if (ED) begin
      if (START) begin
        wa_q <= '0;
        if (state_q == ST_IDLE) begin
          state_q <= ST_FILL;
        end
      end else if (wr_en) begin
        wa_q <= wa_q + 1'b1;
        if (wrap) begin
          ws_q    <= ~ws_q;
          state_q <= ST_STREAM;
        end
      end
      ra_q     <= ra_d;
      rd_act_q <= rd_act_d;
      // Valid / first-sample / bank tags ride alongside the two RAM read stages.
      v1_q  <= rd_act_q;
      f1_q  <= rd_act_q & (ra_q == '0);
      b1_q  <= ~ws_q;
      v2_q  <= v1_q;
      f2_q  <= f1_q;
      b2_q  <= b1_q;
      rdy_q <= f2_q;
      dor_q <= v2_q ? rd_word[DW-1:nb] : '0;
      doi_q <= v2_q ? rd_word[nb-1:0]  : '0;
    end
  end

  assign DOR = dor_q;
  assign DOI = doi_q;
  assign RDY = rdy_q;

endmodule

// File: tb/tb_bitrev_reorder256.sv
// Bench for bitrev_reorder256: frames are tracked as whole sample arrays and the
// expected output timeline is scheduled from the bit-reversal rule directly.
module tb_bitrev_reorder256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ed = 1'b0;
  logic        start = 1'b0;
  logic [11:0] dr = '0;
  logic [11:0] di = '0;
  logic [11:0] dor;
  logic [11:0] doi;
  logic        rdy;

  logic        ed16 = 1'b0;
  logic        start16 = 1'b0;
  logic [15:0] dr16 = '0;
  logic [15:0] di16 = '0;
  logic [15:0] dor16;
  logic [15:0] doi16;
  logic        rdy16;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          t = 0;
  bit          active = 0;
  logic [23:0] cur[$];
  logic [11:0] s_dor[int];
  logic [11:0] s_doi[int];
  bit          s_rdy[int];
  logic [11:0] e_dor = '0;
  logic [11:0] e_doi = '0;
  logic        e_rdy = 1'b0;

  always #5 clk = ~clk;

  bitrev_reorder256 #(.nb(12)) dut (
    .CLK(clk), .RST(rst), .ED(ed), .START(start), .DR(dr), .DI(di),
    .DOR(dor), .DOI(doi), .RDY(rdy)
  );

  bitrev_reorder256 #(.nb(16)) dut16 (
    .CLK(clk), .RST(rst), .ED(ed16), .START(start16), .DR(dr16), .DI(di16),
    .DOR(dor16), .DOI(doi16), .RDY(rdy16)
  );

  function automatic int brev(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // One clock: drive inputs, advance the model, leave expected outputs in e_*.
  task automatic cyc(input bit ed_v, input bit st_v, input bit rst_v,
                     input logic [11:0] dr_v, input logic [11:0] di_v);
    logic [23:0] w;
    ed = ed_v; start = st_v; rst = rst_v; dr = dr_v; di = di_v;
    @(posedge clk);
    #1;
    if (rst_v) begin
      s_dor.delete(); s_doi.delete(); s_rdy.delete(); cur.delete();
      active = 0;
      e_dor = '0; e_doi = '0; e_rdy = 1'b0;
    end else if (ed_v) begin
      t++;
      if (st_v) begin
        active = 1;
        cur.delete();
      end else if (active) begin
        cur.push_back({dr_v, di_v});
        if (cur.size() == 256) begin
          for (int m = 0; m < 256; m++) begin
            w = cur[brev(m)];
            s_dor[t + 3 + m] = w[23:12];
            s_doi[t + 3 + m] = w[11:0];
          end
          s_rdy[t + 3] = 1'b1;
          cur.delete();
        end
      end
      e_rdy = s_rdy.exists(t) ? 1'b1 : 1'b0;
      e_dor = s_dor.exists(t) ? s_dor[t] : 12'd0;
      e_doi = s_doi.exists(t) ? s_doi[t] : 12'd0;
    end
  endtask

  task automatic test_reset();
    cyc(1, 0, 1, 12'd5, 12'd7);
    checks++;
    if ({rdy, dor, doi} !== 25'd0) begin
      errors++;
      $display("FAIL reset_ed1 got rdy=%b dor=%0d doi=%0d want all 0", rdy, dor, doi);
    end
    cyc(0, 0, 1, 12'd5, 12'd7);
    checks++;
    if ({rdy, dor, doi} !== 25'd0) begin
      errors++;
      $display("FAIL reset_ed0 got rdy=%b dor=%0d doi=%0d want all 0", rdy, dor, doi);
    end
    checks++;
    if ({rdy16, dor16, doi16} !== 33'd0) begin
      errors++;
      $display("FAIL reset_wide got rdy=%b dor=%h doi=%h want all 0", rdy16, dor16, doi16);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 12'($urandom), 12'($urandom));
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL idle k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
    end
  endtask

  task automatic test_natural();
    int rdy_k;
    logic [11:0] want;
    rdy_k = -1;
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 256 + 262; k++) begin
      if (k <= 256) cyc(1, 0, 0, 12'(k - 1), 12'(256 - k));
      else          cyc(1, 0, 0, 0, 0);
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL natural k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
      if (rdy === 1'b1 && rdy_k < 0) rdy_k = k;
      if (k >= 259 && k < 259 + 256) begin
        checks++;
        if (doi !== 12'd255 - dor) begin
          errors++;
          $display("FAIL natural_doi k=%0d got doi=%0d want %0d", k, doi, 12'd255 - dor);
        end
      end
      if (k == 260 || k == 262) begin
        want = (k == 260) ? 12'd128 : 12'd192;
        checks++;
        if (dor !== want) begin
          errors++;
          $display("FAIL natural_order k=%0d got dor=%0d want %0d", k, dor, want);
        end
      end
    end
    checks++;
    if (rdy_k !== 259) begin
      errors++;
      $display("FAIL natural_latency got rdy %0d cycles after sample 255 want 3", rdy_k - 256);
    end
  endtask

  task automatic test_ed_random();
    int edc, iter, m;
    bit e;
    edc = 0; iter = 0; m = -1;
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    while (edc < 256 + 262 && iter < 4000) begin
      e = 1'($urandom_range(0, 1));
      iter++;
      if (e) begin
        edc++;
        cyc(1, 0, 0, (edc <= 256) ? 12'(edc - 1) : 12'd0, (edc <= 256) ? 12'(256 - edc) : 12'd0);
      end else begin
        cyc(0, 0, 0, 12'($urandom), 12'($urandom));
      end
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL ed_random it=%0d ed=%b got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 iter, e, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
      if (e && rdy === 1'b1 && m < 0) m = 0;
      if (e && m >= 0 && m < 256) begin
        checks++;
        if (dor !== 12'(brev(m))) begin
          errors++;
          $display("FAIL ed_random_seq m=%0d got dor=%0d want %0d", m, dor, brev(m));
        end
        m++;
      end
    end
    checks++;
    if (m != 256) begin
      errors++;
      $display("FAIL ed_random_len got %0d outputs want 256", m < 0 ? 0 : m);
    end
  endtask

  task automatic test_back_to_back();
    int rk[$];
    logic [11:0] d_at[int];
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 768 + 262; k++) begin
      if (k <= 768) cyc(1, 0, 0, 12'(k - 1), 12'($urandom));
      else          cyc(1, 0, 0, 0, 0);
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL b2b k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
      if (rdy === 1'b1) rk.push_back(k);
      d_at[k] = dor;
    end
    checks++;
    if (rk.size() < 3) begin
      errors++;
      $display("FAIL b2b_rdy_count got %0d pulses want at least 3", rk.size());
    end else begin
      checks += 3;
      if (rk[1] - rk[0] != 256 || rk[2] - rk[1] != 256) begin
        errors++;
        $display("FAIL b2b_period got %0d,%0d want 256,256", rk[1] - rk[0], rk[2] - rk[1]);
      end
      if (rk[0] != 259) begin
        errors++;
        $display("FAIL b2b_first_rdy got k=%0d want 259", rk[0]);
      end
      if (d_at[rk[2] + 1] !== 12'd640) begin
        errors++;
        $display("FAIL b2b_frame2_m1 got dor=%0d want 640", d_at[rk[2] + 1]);
      end
    end
  endtask

  task automatic test_restart();
    int rnext;
    rnext = -1;
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 875; k++) begin
      if (k <= 256)      cyc(1, 0, 0, 12'(k - 1), 12'($urandom));
      else if (k == 357) cyc(1, 1, 0, 12'($urandom), 12'($urandom));
      else if (k <= 613) cyc(1, 0, 0, 12'($urandom), 12'($urandom));
      else               cyc(1, 0, 0, 0, 0);
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL restart k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
      if (k >= 259 && k < 259 + 256) begin
        checks++;
        if (dor !== 12'(brev(k - 259))) begin
          errors++;
          $display("FAIL restart_frame1 m=%0d got dor=%0d want %0d", k - 259, dor, brev(k - 259));
        end
      end
      if (k > 357 && rdy === 1'b1 && rnext < 0) rnext = k;
    end
    checks++;
    if (rnext - 357 != 259) begin
      errors++;
      $display("FAIL restart_latency got %0d cycles after restart want 259", rnext - 357);
    end
  endtask

  task automatic test_start_at_wrap();
    int r1;
    r1 = -1;
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 774; k++) begin
      if (k == 256)      cyc(1, 1, 0, 12'($urandom), 12'($urandom));
      else if (k <= 512) cyc(1, 0, 0, 12'($urandom), 12'($urandom));
      else               cyc(1, 0, 0, 0, 0);
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL start_wrap k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
      if (rdy === 1'b1 && r1 < 0) r1 = k;
    end
    checks++;
    if (r1 != 515) begin
      errors++;
      $display("FAIL start_wrap_first_rdy got k=%0d want 515", r1);
    end
  endtask

  task automatic test_reset_mid();
    int nrdy;
    nrdy = 0;
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 309; k++) begin
      cyc(1, 0, 0, (k <= 256) ? 12'(k - 1) : 12'd0, 12'($urandom));
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL reset_mid k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
    end
    checks++;
    if (dor !== 12'd76) begin
      errors++;
      $display("FAIL reset_mid_m50 got dor=%0d want 76", dor);
    end
    cyc(1, 0, 1, 12'($urandom), 12'($urandom));
    checks++;
    if ({rdy, dor, doi} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid_clear got rdy=%b dor=%0d doi=%0d want all 0", rdy, dor, doi);
    end
    for (int k = 0; k < 300; k++) begin
      cyc(1, 0, 0, 12'($urandom), 12'($urandom));
      if (rdy === 1'b1) nrdy++;
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL reset_mid_quiet k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
    end
    checks++;
    if (nrdy != 0) begin
      errors++;
      $display("FAIL reset_mid_no_rdy got %0d pulses want 0", nrdy);
    end
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 259; k++) begin
      cyc(1, 0, 0, 12'($urandom), 12'($urandom));
      checks++;
      if ({rdy, dor, doi} !== {e_rdy, e_dor, e_doi}) begin
        errors++;
        $display("FAIL reset_mid_refill k=%0d got rdy=%b dor=%0d doi=%0d want rdy=%b dor=%0d doi=%0d",
                 k, rdy, dor, doi, e_rdy, e_dor, e_doi);
      end
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rdy_after_refill got rdy=%b want 1", rdy);
    end
  endtask

  task automatic test_wide();
    int rk;
    rk = -1;
    ed = 1'b0;
    ed16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0; dr16 = 16'h7FFF; di16 = 16'h8000;
    for (int k = 1; k <= 256 + 3 + 256; k++) begin
      @(posedge clk);
      #1;
      if (rdy16 === 1'b1 && rk < 0) rk = k;
      if (rk > 0 && k < rk + 256) begin
        checks++;
        if ({dor16, doi16} !== {16'h7FFF, 16'h8000}) begin
          errors++;
          $display("FAIL wide k=%0d got dor=%h doi=%h want 7fff 8000", k, dor16, doi16);
        end
      end
    end
    checks++;
    if (rk != 259) begin
      errors++;
      $display("FAIL wide_rdy got k=%0d want 259", rk);
    end
    ed16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_ed_random();
    test_back_to_back();
    test_restart();
    test_start_at_wrap();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
